// File: rtl/exc_arbiter.sv
// Commit-stage exception/interrupt/ERET arbiter feeding cp0 and fetch.
// Flushes the pipe and holds a redirect until fetch accepts it.
module exc_arbiter #(
  parameter logic [31:0] BOOT_VEC = 32'hBFC00380,
  parameter logic [31:0] GEN_OFS  = 32'h00000180,
  parameter logic [31:0] INT_OFS  = 32'h00000200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [6:0]  m_exc,
  input  logic        m_eret,
  input  logic [31:0] m_badaddr,
  input  logic [5:0]  hw_int,
  input  logic [1:0]  sw_int,
  input  logic [7:0]  int_mask,
  input  logic        allow_int,
  input  logic        boot_exp_vec,
  input  logic        special_int_vec,
  input  logic [19:0] ebase,
  input  logic [31:0] epc,
  input  logic        redirect_ready,
  output logic        flush,
  output logic        commit_en,
  output logic        en_exp,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic        exp_bd,
  output logic [31:0] exp_bad_vaddr,
  output logic        exp_badv_we,
  output logic        clean_exl,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic {
    IDLE,
    REDIRECT
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        first;
  logic        accept;
  logic        flush_c;
  logic        commit_c;

  logic        int_pend;
  logic [8:0]  req;
  logic [8:0]  sel;
  logic        ev;
  logic        is_int;
  logic        is_eret;
  logic [4:0]  code;
  logic        use_badaddr;
  logic        badv_we;
  logic [31:0] vec;
  logic [31:0] tgt;
  logic [31:0] epc_val;

  // Requests ordered so bit 0 is the highest priority; isolate lowest set bit
  always_comb begin
    int_pend = allow_int & (|({hw_int, sw_int} & int_mask));
    req      = 9'd0;
    if (m_valid)
      req = {m_eret, m_exc[0], m_exc[1], m_exc[2], m_exc[3],
             m_exc[4], m_exc[5], m_exc[6], int_pend};
    sel = req & (~req + 9'd1);
  end

  // Decode the winning event into cp0 fields
  always_comb begin
    ev          = 1'b1;
    is_int      = 1'b0;
    is_eret     = 1'b0;
    code        = 5'd0;
    use_badaddr = 1'b0;
    badv_we     = 1'b0;
    unique case (1'b1)
      sel[0]: is_int = 1'b1;
      sel[1]: begin
        code    = 5'd4;
        badv_we = 1'b1;
      end
      sel[2]: code = 5'd10;
      sel[3]: code = 5'd12;
      sel[4]: code = 5'd8;
      sel[5]: code = 5'd9;
      sel[6]: begin
        code        = 5'd4;
        use_badaddr = 1'b1;
        badv_we     = 1'b1;
      end
      sel[7]: begin
        code        = 5'd5;
        use_badaddr = 1'b1;
        badv_we     = 1'b1;
      end
      sel[8]: is_eret = 1'b1;
      default: ev = 1'b0;
    endcase
  end

  // Redirect target: exception vector or EPC for ERET
  always_comb begin
    if (boot_exp_vec)
      vec = BOOT_VEC;
    else
      vec = {ebase, 12'h000} +
            ((is_int & special_int_vec) ? INT_OFS : GEN_OFS);
    tgt     = is_eret ? epc : vec;
    epc_val = m_bd ? (m_pc - 32'd4) : m_pc;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    flush_c  = 1'b0;
    commit_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (ev) begin
          accept  = 1'b1;
          flush_c = 1'b1;
          state_n = REDIRECT;
        end else begin
          commit_c = m_valid;
        end
      end
      REDIRECT: begin
        flush_c  = 1'b1;
        commit_c = first;
        if (redirect_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign flush          = rst & flush_c;
  assign commit_en      = rst & commit_c;
  assign redirect_valid = (state == REDIRECT);

  // One-cycle cp0 pulses and captured exception fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first         <= 1'b0;
      en_exp        <= 1'b0;
      clean_exl     <= 1'b0;
      exp_code      <= 5'd0;
      exp_epc       <= 32'd0;
      exp_bd        <= 1'b0;
      exp_bad_vaddr <= 32'd0;
      exp_badv_we   <= 1'b0;
      redirect_pc   <= 32'd0;
    end else begin
      first     <= accept;
      en_exp    <= accept & ~is_eret;
      clean_exl <= accept & is_eret;
      if (accept) begin
        exp_code      <= code;
        exp_epc       <= epc_val;
        exp_bd        <= m_bd;
        exp_bad_vaddr <= use_badaddr ? m_badaddr : m_pc;
        exp_badv_we   <= badv_we;
        redirect_pc   <= tgt;
      end
    end
  end

endmodule

// File: tb/tb_exc_arbiter.sv
// Directed bench for exc_arbiter: vector table plus
// hand sequences for stall, ignore and reset cases.
module tb_exc_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [6:0]  m_exc;
  logic        m_eret;
  logic [31:0] m_badaddr;
  logic [5:0]  hw_int;
  logic [1:0]  sw_int;
  logic [7:0]  int_mask;
  logic        allow_int;
  logic        boot_exp_vec;
  logic        special_int_vec;
  logic [19:0] ebase;
  logic [31:0] epc;
  logic        redirect_ready;
  logic        flush;
  logic        commit_en;
  logic        en_exp;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        exp_bd;
  logic [31:0] exp_bad_vaddr;
  logic        exp_badv_we;
  logic        clean_exl;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_arbiter dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_pc(m_pc),
    .m_bd(m_bd), .m_exc(m_exc), .m_eret(m_eret),
    .m_badaddr(m_badaddr), .hw_int(hw_int), .sw_int(sw_int),
    .int_mask(int_mask), .allow_int(allow_int),
    .boot_exp_vec(boot_exp_vec),
    .special_int_vec(special_int_vec), .ebase(ebase),
    .epc(epc), .redirect_ready(redirect_ready),
    .flush(flush), .commit_en(commit_en), .en_exp(en_exp),
    .exp_code(exp_code), .exp_epc(exp_epc), .exp_bd(exp_bd),
    .exp_bad_vaddr(exp_bad_vaddr), .exp_badv_we(exp_badv_we),
    .clean_exl(clean_exl), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        bd;
    logic [6:0]  exc;
    logic        eret;
    logic [31:0] badaddr;
    logic [5:0]  hw;
    logic [1:0]  sw;
    logic [7:0]  mask;
    logic        allow;
    logic        bev;
    logic        iv;
    logic [19:0] eb;
    logic [31:0] epc_in;
    logic        x_en;
    logic        x_clean;
    logic [4:0]  x_code;
    logic [31:0] x_epc;
    logic        x_bd;
    logic [31:0] x_badv;
    logic        x_we;
    logic [31:0] x_rpc;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m_valid = 1'b0; m_pc = 32'h0; m_bd = 1'b0; m_exc = 7'h0;
    m_eret = 1'b0; m_badaddr = 32'h0; hw_int = 6'h0;
    sw_int = 2'h0; int_mask = 8'h0; allow_int = 1'b0;
    boot_exp_vec = 1'b0; special_int_vec = 1'b0;
    ebase = 20'h80000; epc = 32'h0; redirect_ready = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".flush"}, {31'd0, flush}, 32'd0);
    chk({nm, ".commit"}, {31'd0, commit_en}, 32'd0);
    chk({nm, ".en_exp"}, {31'd0, en_exp}, 32'd0);
    chk({nm, ".clean"}, {31'd0, clean_exl}, 32'd0);
    chk({nm, ".rvalid"}, {31'd0, redirect_valid}, 32'd0);
    chk({nm, ".rpc"}, redirect_pc, 32'd0);
    chk({nm, ".code"}, {27'd0, exp_code}, 32'd0);
    chk({nm, ".epc"}, exp_epc, 32'd0);
    chk({nm, ".badv"}, exp_bad_vaddr, 32'd0);
    chk({nm, ".we"}, {31'd0, exp_badv_we}, 32'd0);
    chk({nm, ".bd"}, {31'd0, exp_bd}, 32'd0);
  endtask

  initial begin
    //    name     pc          bd  exc          eret badaddr
    //    hw       sw    mask  al bev iv eb     epc
    //    en cl code epc       bd badv        we  rpc
    tbl[0] = '{"sys", 32'h80001000, 0, 7'b0001000, 0, 0,
               0, 0, 8'h00, 0, 0, 0, 20'h80000, 0,
               1, 0, 8, 32'h80001000, 0, 32'h80001000, 0,
               32'h80000180};
    tbl[1] = '{"ov_bd", 32'h80001000, 1, 7'b0010000, 0, 0,
               0, 0, 8'h00, 0, 0, 0, 20'h80000, 0,
               1, 0, 12, 32'h80000FFC, 1, 32'h80001000, 0,
               32'h80000180};
    tbl[2] = '{"int_ri", 32'h80001000, 0, 7'b0100000, 0, 0,
               6'h20, 0, 8'h80, 1, 0, 1, 20'h80000, 0,
               1, 0, 0, 32'h80001000, 0, 32'h80001000, 0,
               32'h80000200};
    tbl[3] = '{"ri_mask", 32'h80001000, 0, 7'b0100000, 0, 0,
               6'h20, 0, 8'h00, 1, 0, 1, 20'h80000, 0,
               1, 0, 10, 32'h80001000, 0, 32'h80001000, 0,
               32'h80000180};
    tbl[4] = '{"eret", 32'h80002000, 0, 7'b0000000, 1, 0,
               0, 0, 8'h00, 0, 0, 0, 20'h80000, 32'hBFC00704,
               0, 1, 0, 0, 0, 0, 0,
               32'hBFC00704};
    tbl[5] = '{"adelif", 32'h80001002, 0, 7'b1000010, 0, 32'h1235,
               0, 0, 8'h00, 0, 0, 0, 20'h80000, 0,
               1, 0, 4, 32'h80001002, 0, 32'h80001002, 1,
               32'h80000180};
    tbl[6] = '{"adel_d", 32'h80003000, 0, 7'b0000010, 0, 32'h1235,
               0, 0, 8'h00, 0, 0, 0, 20'h80000, 0,
               1, 0, 4, 32'h80003000, 0, 32'h00001235, 1,
               32'h80000180};
    tbl[7] = '{"bp_ades", 32'h80003004, 0, 7'b0000101, 0, 32'h77,
               0, 0, 8'h00, 0, 0, 0, 20'h80000, 0,
               1, 0, 9, 32'h80003004, 0, 32'h80003004, 0,
               32'h80000180};
    tbl[8] = '{"sys_eret", 32'h80004000, 0, 7'b0001000, 1, 0,
               0, 0, 8'h00, 0, 0, 0, 20'h80000, 32'h1234,
               1, 0, 8, 32'h80004000, 0, 32'h80004000, 0,
               32'h80000180};
    tbl[9] = '{"sw_int", 32'h80005000, 1, 7'b0000000, 0, 0,
               0, 2'b01, 8'h01, 1, 0, 0, 20'h9A000, 0,
               1, 0, 0, 32'h80004FFC, 1, 32'h80005000, 0,
               32'h9A000180};
    tbl[10] = '{"int_off", 32'h80001000, 0, 7'b0100000, 0, 0,
                6'h20, 0, 8'h80, 0, 0, 1, 20'h80000, 0,
                1, 0, 10, 32'h80001000, 0, 32'h80001000, 0,
                32'h80000180};

    idle_inputs();
    rst = 1'b0;
    m_valid = 1'b1;
    m_exc = 7'b0001000;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;

    // plain commit with no event
    m_valid = 1'b1;
    #1;
    chk("norm.commit", {31'd0, commit_en}, 32'd1);
    chk("norm.flush", {31'd0, flush}, 32'd0);
    @(posedge clk); #1;
    chk("norm.en_exp", {31'd0, en_exp}, 32'd0);
    chk("norm.rvalid", {31'd0, redirect_valid}, 32'd0);
    m_valid = 1'b0;
    #1;
    chk("norm.nocommit", {31'd0, commit_en}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      idle_inputs();
      m_valid = 1'b1;
      m_pc = tbl[i].pc; m_bd = tbl[i].bd; m_exc = tbl[i].exc;
      m_eret = tbl[i].eret; m_badaddr = tbl[i].badaddr;
      hw_int = tbl[i].hw; sw_int = tbl[i].sw;
      int_mask = tbl[i].mask; allow_int = tbl[i].allow;
      boot_exp_vec = tbl[i].bev; special_int_vec = tbl[i].iv;
      ebase = tbl[i].eb; epc = tbl[i].epc_in;
      #1;
      chk({tbl[i].name, ".flushT"}, {31'd0, flush}, 32'd1);
      chk({tbl[i].name, ".commitT"}, {31'd0, commit_en}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      #1;
      chk({tbl[i].name, ".en_exp"}, {31'd0, en_exp},
          {31'd0, tbl[i].x_en});
      chk({tbl[i].name, ".clean"}, {31'd0, clean_exl},
          {31'd0, tbl[i].x_clean});
      chk({tbl[i].name, ".commit"}, {31'd0, commit_en}, 32'd1);
      chk({tbl[i].name, ".rvalid"}, {31'd0, redirect_valid}, 32'd1);
      chk({tbl[i].name, ".rpc"}, redirect_pc, tbl[i].x_rpc);
      if (tbl[i].x_en) begin
        chk({tbl[i].name, ".code"}, {27'd0, exp_code},
            {27'd0, tbl[i].x_code});
        chk({tbl[i].name, ".epc"}, exp_epc, tbl[i].x_epc);
        chk({tbl[i].name, ".bd"}, {31'd0, exp_bd},
            {31'd0, tbl[i].x_bd});
        chk({tbl[i].name, ".badv"}, exp_bad_vaddr, tbl[i].x_badv);
        chk({tbl[i].name, ".we"}, {31'd0, exp_badv_we},
            {31'd0, tbl[i].x_we});
      end
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      chk({tbl[i].name, ".idle"}, {31'd0, redirect_valid}, 32'd0);
      chk({tbl[i].name, ".pulse_off"}, {31'd0, en_exp | clean_exl},
          32'd0);
    end

    // ades held off by fetch for 5 cycles while new events arrive
    @(negedge clk);
    idle_inputs();
    m_valid = 1'b1; m_pc = 32'h80006000; m_exc = 7'b0000001;
    m_badaddr = 32'h3; boot_exp_vec = 1'b1;
    @(posedge clk); #1;
    chk("stall.en_exp", {31'd0, en_exp}, 32'd1);
    chk("stall.code", {27'd0, exp_code}, 32'd5);
    chk("stall.we", {31'd0, exp_badv_we}, 32'd1);
    chk("stall.badv", exp_bad_vaddr, 32'h3);
    m_pc = 32'h80007000; m_exc = 7'b0001000; m_badaddr = 32'h40;
    boot_exp_vec = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall.flush", {31'd0, flush}, 32'd1);
      chk("stall.rvalid", {31'd0, redirect_valid}, 32'd1);
      chk("stall.rpc", redirect_pc, 32'hBFC00380);
      chk("stall.ignore", {30'd0, en_exp, commit_en}, 32'd0);
      chk("stall.code_hold", {27'd0, exp_code}, 32'd5);
    end
    @(negedge clk);
    m_valid = 1'b0;
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    chk("stall.idle", {31'd0, redirect_valid}, 32'd0);
    chk("stall.noflush", {31'd0, flush}, 32'd0);

    // reset while redirecting drops the redirect
    @(negedge clk);
    idle_inputs();
    m_valid = 1'b1; m_pc = 32'h80008000; m_exc = 7'b0010000;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("rst.pre_rvalid", {31'd0, redirect_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("rst.no_en", {31'd0, en_exp}, 32'd0);
      chk("rst.no_rv", {31'd0, redirect_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
